// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Multi-cycle instruction-fetch sequencer. It owns the PC and drives a req/ack
// instruction-memory port that may insert wait states. Fetched words go to
// decode over a valid/ready handshake. The block also applies branches,
// redirects (flushes), a fetch timeout and an alignment check.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_branch       branch instruction in decode
//   i_alu_zero     ALU zero flag for the same instruction
//   i_jump         branch offset, already shifted left by 1
//   i_flush        redirect request from a later stage
//   i_flush_addr   redirect target
//   o_imem_req     memory request (registered)
//   o_imem_addr    request address, always equal to the PC
//   i_imem_ack     memory ack; i_imem_rdata is valid in the same cycle
//   i_imem_rdata   fetched word
//   o_inst_valid   o_inst / o_pc_out valid for decode (registered)
//   i_inst_ready   decode accepts the instruction
//   o_inst         registered instruction
//   o_pc_out       address of o_inst
//   o_fetch_err    sticky error: timeout or misaligned target
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | one cycle after reset release, before the first request
// REQ   | request outstanding at r_pc, waiting for ack
// HOLD  | instruction presented to decode, waiting for transfer
// ERR   | timeout or misaligned target; only reset leaves this state
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int                          INST_ADDR_WIDTH = 32,
  parameter int                          INST_WIDTH      = 32,
  parameter logic [INST_ADDR_WIDTH-1:0]  RESET_PC        = '0,
  parameter int                          MAX_WAIT        = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_branch,
  input  logic                        i_alu_zero,
  input  logic [INST_ADDR_WIDTH-1:0]  i_jump,
  input  logic                        i_flush,
  input  logic [INST_ADDR_WIDTH-1:0]  i_flush_addr,
  output logic                        o_imem_req,
  output logic [INST_ADDR_WIDTH-1:0]  o_imem_addr,
  input  logic                        i_imem_ack,
  input  logic [INST_WIDTH-1:0]       i_imem_rdata,
  output logic                        o_inst_valid,
  input  logic                        i_inst_ready,
  output logic [INST_WIDTH-1:0]       o_inst,
  output logic [INST_ADDR_WIDTH-1:0]  o_pc_out,
  output logic                        o_fetch_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Timeout fires at the end of the MAX_WAIT-th REQ cycle without ack.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t                       r_state;
  logic [INST_ADDR_WIDTH-1:0]   r_pc;
  logic [INST_ADDR_WIDTH-1:0]   r_pc_out;
  logic [INST_ADDR_WIDTH-1:0]   r_tgt;
  logic [INST_WIDTH-1:0]        r_inst;
  logic [7:0]                   r_wait_cnt;
  logic                         r_pend;
  logic                         r_imem_req;
  logic                         r_inst_valid;
  logic                         r_err;

  logic                         w_taken;
  logic [INST_ADDR_WIDTH-1:0]   w_next_pc;
  logic                         w_next_ok;
  logic                         w_flush_ok;
  logic [INST_ADDR_WIDTH-1:0]   w_redir_addr;
  logic                         w_redir_ok;
  logic                         w_redirect;

  // Next sequential/branch PC from the instruction being transferred.
  assign w_taken   = i_branch & i_alu_zero;
  assign w_next_pc = w_taken ? (r_pc_out + i_jump)
                             : (r_pc_out + INST_ADDR_WIDTH'(4));
  assign w_next_ok = (w_next_pc[1:0] == 2'b00);

  assign w_flush_ok = (i_flush_addr[1:0] == 2'b00);

  // In REQ, a flush arriving together with the ack is newer than any stored
  // target, so it wins over r_tgt and the returning data is dropped.
  assign w_redirect   = r_pend | i_flush;
  assign w_redir_addr = i_flush ? i_flush_addr : r_tgt;
  assign w_redir_ok   = (w_redir_addr[1:0] == 2'b00);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_pc_out     <= '0;
      r_tgt        <= '0;
      r_inst       <= '0;
      r_wait_cnt   <= '0;
      r_pend       <= 1'b0;
      r_imem_req   <= 1'b0;
      r_inst_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_flush && !w_flush_ok) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else begin
            if (i_flush) r_pc <= i_flush_addr;
            r_state    <= REQ;
            r_imem_req <= 1'b1;
            r_wait_cnt <= '0;
          end
        end

        REQ: begin
          if (i_imem_ack) begin
            if (w_redirect) begin
              // Request completed but superseded: drop data, refetch.
              r_pend <= 1'b0;
              if (!w_redir_ok) begin
                r_state    <= ERR;
                r_imem_req <= 1'b0;
                r_err      <= 1'b1;
              end else begin
                r_pc       <= w_redir_addr;
                r_wait_cnt <= '0;
              end
            end else begin
              r_inst       <= i_imem_rdata;
              r_pc_out     <= r_pc;
              r_inst_valid <= 1'b1;
              r_imem_req   <= 1'b0;
              r_state      <= HOLD;
            end
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_state    <= ERR;
            r_imem_req <= 1'b0;
            r_pend     <= 1'b0;
            r_err      <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            // The outstanding request is never aborted; remember the target.
            if (i_flush) begin
              r_pend <= 1'b1;
              r_tgt  <= i_flush_addr;
            end
          end
        end

        HOLD: begin
          if (i_flush) begin
            r_inst_valid <= 1'b0;
            if (!w_flush_ok) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_pc       <= i_flush_addr;
              r_state    <= REQ;
              r_imem_req <= 1'b1;
              r_wait_cnt <= '0;
            end
          end else if (i_inst_ready) begin
            r_inst_valid <= 1'b0;
            if (!w_next_ok) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_pc       <= w_next_pc;
              r_state    <= REQ;
              r_imem_req <= 1'b1;
              r_wait_cnt <= '0;
            end
          end
        end

        ERR: begin
          r_imem_req   <= 1'b0;
          r_inst_valid <= 1'b0;
          r_err        <= 1'b1;
        end

        default: begin
          r_state <= ERR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign o_imem_req   = r_imem_req;
  assign o_imem_addr  = r_pc;
  assign o_inst_valid = r_inst_valid;
  assign o_inst       = r_inst;
  assign o_pc_out     = r_pc_out;
  assign o_fetch_err  = r_err;

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed bench for fetch_ctrl: sequential fetch, wait states, branches,
// flush during REQ/HOLD, timeout, misaligned targets and PC wrap-around.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch;
  logic        alu_zero;
  logic [31:0] jump;
  logic        flush;
  logic [31:0] flush_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc_out;
  logic        fetch_err;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl #(
    .INST_ADDR_WIDTH (32),
    .INST_WIDTH      (32),
    .RESET_PC        (32'h0),
    .MAX_WAIT        (15)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_branch     (branch),
    .i_alu_zero   (alu_zero),
    .i_jump       (jump),
    .i_flush      (flush),
    .i_flush_addr (flush_addr),
    .o_imem_req   (imem_req),
    .o_imem_addr  (imem_addr),
    .i_imem_ack   (imem_ack),
    .i_imem_rdata (imem_rdata),
    .o_inst_valid (inst_valid),
    .i_inst_ready (inst_ready),
    .o_inst       (inst),
    .o_pc_out     (pc_out),
    .o_fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect a request at exp_addr, hold it for `waits` cycles, then ack.
  task automatic do_fetch(input string tag, input logic [31:0] exp_addr,
                          input int waits, input logic [31:0] data);
    chk({tag, ".req"},  {31'd0, imem_req}, 32'd1);
    chk({tag, ".addr"}, imem_addr, exp_addr);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk({tag, ".wait_req"},   {31'd0, imem_req}, 32'd1);
      chk({tag, ".wait_addr"},  imem_addr, exp_addr);
      chk({tag, ".wait_valid"}, {31'd0, inst_valid}, 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk({tag, ".valid"},  {31'd0, inst_valid}, 32'd1);
    chk({tag, ".inst"},   inst, data);
    chk({tag, ".pc_out"}, pc_out, exp_addr);
    chk({tag, ".req_lo"}, {31'd0, imem_req}, 32'd0);
    chk({tag, ".err"},    {31'd0, fetch_err}, 32'd0);
  endtask

  // Transfer from HOLD with the given branch/flush inputs; expect a new REQ.
  task automatic xfer(input string tag, input logic br, input logic z,
                      input logic [31:0] jmp, input logic fl,
                      input logic [31:0] fla, input logic [31:0] exp_addr);
    inst_ready = 1'b1;
    branch     = br;
    alu_zero   = z;
    jump       = jmp;
    flush      = fl;
    flush_addr = fla;
    tick();
    inst_ready = 1'b0;
    branch     = 1'b0;
    alu_zero   = 1'b0;
    jump       = 32'h0;
    flush      = 1'b0;
    flush_addr = 32'h0;
    chk({tag, ".valid_lo"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, ".req"},      {31'd0, imem_req}, 32'd1);
    chk({tag, ".next"},     imem_addr, exp_addr);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.req",   {31'd0, imem_req}, 32'd0);
    chk("rst.valid", {31'd0, inst_valid}, 32'd0);
    chk("rst.err",   {31'd0, fetch_err}, 32'd0);
    chk("rst.addr",  imem_addr, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("idle.req", {31'd0, imem_req}, 32'd0);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    branch     = 1'b0;
    alu_zero   = 1'b0;
    jump       = 32'h0;
    flush      = 1'b0;
    flush_addr = 32'h0;
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    inst_ready = 1'b0;

    do_reset();
    chk("rst.inst",   inst, 32'h0);
    chk("rst.pc_out", pc_out, 32'h0);

    // 1: zero-wait sequential fetch 0,4,8,C
    do_fetch("t1a", 32'h0, 0, 32'hA000_0000);
    xfer("t1a", 0, 0, 32'h0, 0, 32'h0, 32'h4);
    do_fetch("t1b", 32'h4, 0, 32'hA000_0004);
    xfer("t1b", 0, 0, 32'h0, 0, 32'h0, 32'h8);
    do_fetch("t1c", 32'h8, 0, 32'hA000_0008);
    xfer("t1c", 0, 0, 32'h0, 0, 32'h0, 32'hC);

    // 2: three wait states at 0xC
    do_fetch("t2", 32'hC, 3, 32'hB000_000C);
    xfer("t2", 0, 0, 32'h0, 0, 32'h0, 32'h10);

    // 3: branch taken / not taken at pc_out 0x10, HOLD stable when not ready
    do_fetch("t3a", 32'h10, 0, 32'hC000_0010);
    tick();
    chk("t3.hold_valid", {31'd0, inst_valid}, 32'd1);
    chk("t3.hold_inst",  inst, 32'hC000_0010);
    chk("t3.hold_pc",    pc_out, 32'h10);
    xfer("t3.taken", 1, 1, 32'h20, 0, 32'h0, 32'h30);
    do_fetch("t3b", 32'h30, 0, 32'hC000_0030);
    // flush in HOLD back to 0x10
    flush      = 1'b1;
    flush_addr = 32'h10;
    tick();
    flush      = 1'b0;
    flush_addr = 32'h0;
    chk("t3.hflush_valid", {31'd0, inst_valid}, 32'd0);
    chk("t3.hflush_req",   {31'd0, imem_req}, 32'd1);
    chk("t3.hflush_addr",  imem_addr, 32'h10);
    do_fetch("t3c", 32'h10, 0, 32'hC000_0010);
    xfer("t3.nottaken", 1, 0, 32'h20, 0, 32'h0, 32'h14);

    // 4: flush during REQ; request held, ack data dropped, later flush wins
    flush      = 1'b1;
    flush_addr = 32'h40;
    tick();
    flush_addr = 32'h80;
    tick();
    flush      = 1'b0;
    flush_addr = 32'h0;
    chk("t4.held_req",  {31'd0, imem_req}, 32'd1);
    chk("t4.held_addr", imem_addr, 32'h14);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    chk("t4.drop_valid", {31'd0, inst_valid}, 32'd0);
    chk("t4.new_req",    {31'd0, imem_req}, 32'd1);
    chk("t4.new_addr",   imem_addr, 32'h80);
    do_fetch("t4", 32'h80, 0, 32'hD000_0080);
    xfer("t4.flush_wins", 1, 1, 32'h20, 1, 32'h80, 32'h80);

    // 6b: wrap-around 0xFFFFFFFC + 4 -> 0
    do_fetch("t6w", 32'h80, 0, 32'hD000_0080);
    xfer("t6w.flush", 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    do_fetch("t6w.top", 32'hFFFF_FFFC, 0, 32'hE000_FFFC);
    xfer("t6w.wrap", 0, 0, 32'h0, 0, 32'h0, 32'h0);

    // 5: timeout after 15 REQ cycles without ack
    repeat (14) tick();
    chk("t5.req_at14", {31'd0, imem_req}, 32'd1);
    chk("t5.err_at14", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("t5.err",    {31'd0, fetch_err}, 32'd1);
    chk("t5.req_lo", {31'd0, imem_req}, 32'd0);
    flush      = 1'b1;
    flush_addr = 32'h40;
    repeat (2) tick();
    flush      = 1'b0;
    flush_addr = 32'h0;
    chk("t5.flush_ign_err", {31'd0, fetch_err}, 32'd1);
    chk("t5.flush_ign_req", {31'd0, imem_req}, 32'd0);
    chk("t5.flush_ign_val", {31'd0, inst_valid}, 32'd0);
    do_reset();
    chk("t5.restart_req",  {31'd0, imem_req}, 32'd1);
    chk("t5.restart_addr", imem_addr, 32'h0);

    // async reset drops imem_req immediately; ack during reset ignored
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk("arst.req_lo", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    chk("arst.valid", {31'd0, inst_valid}, 32'd0);
    do_reset();

    // 6a: misaligned branch target -> error, no request
    do_fetch("t6m", 32'h0, 0, 32'hF000_0000);
    inst_ready = 1'b1;
    branch     = 1'b1;
    alu_zero   = 1'b1;
    jump       = 32'h2;
    tick();
    inst_ready = 1'b0;
    branch     = 1'b0;
    alu_zero   = 1'b0;
    jump       = 32'h0;
    chk("t6m.err",   {31'd0, fetch_err}, 32'd1);
    chk("t6m.req",   {31'd0, imem_req}, 32'd0);
    chk("t6m.valid", {31'd0, inst_valid}, 32'd0);
    tick();
    chk("t6m.req2",  {31'd0, imem_req}, 32'd0);

    // misaligned flush target in HOLD -> error
    do_reset();
    do_fetch("t6f", 32'h0, 0, 32'hF100_0000);
    flush      = 1'b1;
    flush_addr = 32'h6;
    tick();
    flush      = 1'b0;
    flush_addr = 32'h0;
    chk("t6f.err", {31'd0, fetch_err}, 32'd1);
    chk("t6f.req", {31'd0, imem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
